turn_sequencer: RTL and testbench



---
 rtl/turn_sequencer.sv | 137 +++++++++++++
 tb/tb_turn_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Mastermind round controller: walks each turn through guess entry, scoring and
// peg drawing, then decides whether the game is won, lost or moves to the next turn.
module turn_sequencer #(
  parameter int MAX_TURNS = 10,
  parameter int PEGS      = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             guess_valid,
  output logic             guess_ready,
  input  logic             timeout,
  output logic             next_turn,
  output logic             score_start,
  input  logic             score_valid,
  input  logic [CNT_W-1:0] exact_count,
  output logic             draw_start,
  input  logic             draw_done,
  output logic [3:0]       turn_num,
  output logic             turn_forfeit,
  output logic             game_won,
  output logic             game_lost
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_SCORE = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [2:0] S_LOSE  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [3:0]       turn_q, turn_d;
  logic             forfeit_q, forfeit_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             guess_ready_q, guess_ready_d;
  logic             next_turn_q, next_turn_d;
  logic             score_start_q, score_start_d;
  logic             draw_start_q, draw_start_d;
  logic             game_won_q, game_won_d;
  logic             game_lost_q, game_lost_d;

  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    forfeit_d = forfeit_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d   = S_PLAY;
          turn_d    = 4'd1;
          forfeit_d = 1'b0;
          count_d   = '0;
        end
      end
      S_PLAY: begin
        // A guess arriving together with timeout takes precedence.
        if (guess_valid) begin
          state_d = S_SCORE;
        end else if (timeout) begin
          state_d   = S_DRAW;
          forfeit_d = 1'b1;
          count_d   = '0;
        end
      end
      S_SCORE: begin
        if (score_valid) begin
          state_d = S_DRAW;
          count_d = exact_count;
        end
      end
      S_DRAW: begin
        if (draw_done) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (count_q == CNT_W'(PEGS)) begin
          state_d = S_WIN;
        end else if (turn_q == 4'(MAX_TURNS)) begin
          state_d = S_LOSE;
        end else begin
          state_d   = S_PLAY;
          turn_d    = turn_q + 4'd1;
          forfeit_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the upcoming state so every pulse lands on the
    // first cycle of the state it announces.
    guess_ready_d = (state_d == S_PLAY);
    next_turn_d   = (state_d == S_PLAY)  && (state_q != S_PLAY);
    score_start_d = (state_d == S_SCORE) && (state_q != S_SCORE);
    draw_start_d  = (state_d == S_DRAW)  && (state_q != S_DRAW);
    game_won_d    = (state_d == S_WIN);
    game_lost_d   = (state_d == S_LOSE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      turn_q        <= 4'd0;
      forfeit_q     <= 1'b0;
      count_q       <= '0;
      guess_ready_q <= 1'b0;
      next_turn_q   <= 1'b0;
      score_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
      game_won_q    <= 1'b0;
      game_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      turn_q        <= turn_d;
      forfeit_q     <= forfeit_d;
      count_q       <= count_d;
      guess_ready_q <= guess_ready_d;
      next_turn_q   <= next_turn_d;
      score_start_q <= score_start_d;
      draw_start_q  <= draw_start_d;
      game_won_q    <= game_won_d;
      game_lost_q   <= game_lost_d;
    end
  end

  assign guess_ready  = guess_ready_q;
  assign next_turn    = next_turn_q;
  assign score_start  = score_start_q;
  assign draw_start   = draw_start_q;
  assign turn_num     = turn_q;
  assign turn_forfeit = forfeit_q;
  assign game_won     = game_won_q;
  assign game_lost    = game_lost_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: win, full-length loss, forfeit, event
// filtering and asynchronous reset abort, with hand-computed expectations.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, guess_valid, timeout, score_valid, draw_done;
  logic [2:0] exact_count;
  logic       guess_ready, next_turn, score_start, draw_start;
  logic [3:0] turn_num;
  logic       turn_forfeit, game_won, game_lost;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  turn_sequencer #(.MAX_TURNS(10), .PEGS(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .guess_valid(guess_valid), .guess_ready(guess_ready),
    .timeout(timeout), .next_turn(next_turn),
    .score_start(score_start), .score_valid(score_valid),
    .exact_count(exact_count), .draw_start(draw_start),
    .draw_done(draw_done), .turn_num(turn_num),
    .turn_forfeit(turn_forfeit), .game_won(game_won), .game_lost(game_lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full scored turn starting in its first PLAY cycle; ends one cycle
  // after CHECK (next PLAY, WIN or LOSE).
  task automatic do_turn(input logic [2:0] cnt);
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    score_valid = 1'b1;
    exact_count = cnt;
    tick();
    score_valid = 1'b0;
    draw_done   = 1'b1;
    tick();
    draw_done   = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; guess_valid = 1'b0; timeout = 1'b0;
    score_valid = 1'b0; draw_done = 1'b0; exact_count = 3'd0;
    tick(); tick();
    check("rst_turn", 32'(turn_num), 0);
    check("rst_outs", {guess_ready, next_turn, score_start, draw_start,
                       turn_forfeit, game_won, game_lost}, 0);
    resetn = 1'b1;
    tick();
    check("release_no_pulse", {next_turn, guess_ready}, 0);

    // Game 1: immediate win.
    start = 1'b1; tick(); start = 1'b0;
    check("g1_next_turn", 32'(next_turn), 1);
    check("g1_turn", 32'(turn_num), 1);
    check("g1_ready", 32'(guess_ready), 1);
    tick();
    check("g1_next_turn_once", 32'(next_turn), 0);
    guess_valid = 1'b1; tick(); guess_valid = 1'b0;
    check("g1_score_start", {score_start, guess_ready}, 2'b10);
    tick();
    check("g1_score_start_once", 32'(score_start), 0);
    score_valid = 1'b1; exact_count = 3'd4; tick(); score_valid = 1'b0;
    check("g1_draw_start", 32'(draw_start), 1);
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    check("g1_check_not_won", {game_won, draw_start}, 0);
    tick();
    check("g1_won", {game_won, game_lost}, 2'b10);
    check("g1_turn_held", 32'(turn_num), 1);

    // Game 2 starts from WIN, then plays ten losing turns.
    start = 1'b1; tick(); start = 1'b0;
    check("g2_restart", {game_won, next_turn, turn_num}, {1'b0, 1'b1, 4'd1});
    for (int t = 1; t <= 10; t++) begin
      check($sformatf("g2_turn%0d", t), {next_turn, turn_num}, {1'b1, 4'(t)});
      do_turn(3'd2);
    end
    check("g2_lost", {game_lost, game_won, next_turn}, 3'b100);
    check("g2_turn_held", 32'(turn_num), 10);
    tick();
    check("g2_no_11th", {next_turn, game_lost}, 2'b01);

    // Game 3 from LOSE: forfeit at turn 3.
    start = 1'b1; tick(); start = 1'b0;
    check("g3_restart", {game_lost, next_turn, turn_num}, {1'b0, 1'b1, 4'd1});
    do_turn(3'd1);
    do_turn(3'd0);
    check("g3_turn3", {next_turn, turn_num}, {1'b1, 4'd3});
    timeout = 1'b1; tick(); timeout = 1'b0;
    check("g3_forfeit", {turn_forfeit, draw_start, score_start, guess_ready}, 4'b1100);
    timeout = 1'b1; tick(); timeout = 1'b0;
    check("g3_timeout_in_draw", {turn_forfeit, draw_start, turn_num}, {1'b1, 1'b0, 4'd3});
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    tick();
    check("g3_turn4", {turn_forfeit, next_turn, turn_num}, {1'b0, 1'b1, 4'd4});

    // Coincident guess and timeout: guess wins.
    guess_valid = 1'b1; timeout = 1'b1; tick(); guess_valid = 1'b0; timeout = 1'b0;
    check("coinc_score", {score_start, turn_forfeit, draw_start}, 3'b100);
    timeout = 1'b1; tick(); timeout = 1'b0;
    check("timeout_in_score", {score_start, draw_start, guess_ready, turn_forfeit}, 0);
    score_valid = 1'b1; exact_count = 3'd1; tick(); score_valid = 1'b0;
    check("t4_draw_start", 32'(draw_start), 1);
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_draw", {next_turn, draw_start, turn_num}, {1'b0, 1'b0, 4'd4});
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    tick();
    check("t5_entry", {next_turn, turn_num}, {1'b1, 4'd5});

    // Asynchronous reset mid-SCORE.
    guess_valid = 1'b1; tick(); guess_valid = 1'b0;
    check("t5_score", 32'(score_start), 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst", {guess_ready, next_turn, score_start, draw_start,
                        turn_forfeit, game_won, game_lost, turn_num}, 0);
    tick();
    resetn = 1'b1;
    tick();
    check("after_rst_idle", {next_turn, guess_ready, turn_num}, 0);
    score_valid = 1'b1; exact_count = 3'd4; draw_done = 1'b1; tick();
    score_valid = 1'b0; draw_done = 1'b0;
    check("idle_ignores", {draw_start, game_won, turn_num}, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("post_rst_start", {next_turn, turn_num}, {1'b1, 4'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
